// File: rtl/dota_sample_sequencer.sv
// Sequencer for the digital OTA/comparator cell: enable, settle, sample a programmable
// window of synchronized OTA outputs, and hand the high / high-Z counts to the host.
module dota_sample_sequencer #(
  parameter int SETTLE_CYC = 4,
  parameter int WIN_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             cmp_in,
  input  logic             cmp_drv,
  output logic             ota_enable,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIN_W-1:0] res_high,
  output logic [WIN_W-1:0] res_hiz
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  logic [1:0]       state;
  logic [SW-1:0]    settle_cnt;
  logic [WIN_W-1:0] meas_cnt;
  logic [WIN_W-1:0] win_q;
  logic             cmp_s1, cmp_s2;
  logic             drv_s1, drv_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      meas_cnt   <= '0;
      win_q      <= '0;
      res_high   <= '0;
      res_hiz    <= '0;
      cmp_s1     <= 1'b0;
      cmp_s2     <= 1'b0;
      drv_s1     <= 1'b0;
      drv_s2     <= 1'b0;
    end else begin
      cmp_s1 <= cmp_in;
      cmp_s2 <= cmp_s1;
      drv_s1 <= cmp_drv;
      drv_s2 <= drv_s1;
      case (state)
        IDLE: begin
          if (start) begin
            win_q      <= win_len;
            res_high   <= '0;
            res_hiz    <= '0;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            meas_cnt <= '0;
            // A zero-length window skips sampling entirely.
            state    <= (win_q == '0) ? DONE : MEASURE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        MEASURE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            if (!drv_s2)
              res_hiz <= res_hiz + WIN_W'(1);
            else if (cmp_s2)
              res_high <= res_high + WIN_W'(1);
            if (meas_cnt == win_q - WIN_W'(1))
              state <= DONE;
            else
              meas_cnt <= meas_cnt + WIN_W'(1);
          end
        end
        default: begin
          if (res_ready)
            state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (state == SETTLE) || (state == MEASURE);
  assign ota_enable = busy;
  assign res_valid  = (state == DONE);

endmodule
